// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the data-RAM access path: funct3 codes, byte-enable
// patterns and the arbiter FSM state encoding.
package mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Two-requester load/store bus: packed request fields {r1,r0} plus a shared
// response channel steered by per-requester valid bits.
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [5:0]              req_funct3;
  logic [2*(ADDR_W+2)-1:0] req_addr;
  logic [63:0]             req_wdata;
  logic [1:0]              rsp_valid;
  logic [31:0]             rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_lane_align.sv
// Combinational byte-lane logic: store be/wdata replication and legality check
// for the incoming request, plus load byte/half extraction and extension.
module ram_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        err,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] q,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    err = 1'b0;
    case (funct3)
      F3_B, F3_BU: err = 1'b0;
      F3_H, F3_HU: err = addr_lo[0];
      F3_W:        err = (addr_lo != 2'b00);
      default:     err = 1'b1;
    endcase
    // Stores only have signed-free encodings SB/SH/SW.
    if (we && (funct3 > F3_W)) begin
      err = 1'b1;
    end
  end

  always_comb begin
    be         = BE_WORD;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = BE_BYTE << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_sel = q[{ld_addr_lo, 3'b000} +: 8];
  assign half_sel = ld_addr_lo[1] ? q[31:16] : q[15:0];

  always_comb begin
    rdata = q;
    case (ld_funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {24'h0, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata = {16'h0, half_sel};
      default: rdata = q;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter and transaction sequencer between two load/store
// requesters and a byte-enabled RAM with one-cycle registered read.
module ram_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_access_arbiter_if.slave   bus,
  output logic                  ram_we,
  output logic [3:0]            ram_be,
  output logic [ADDR_W-1:0]     ram_waddr,
  output logic [ADDR_W-1:0]     ram_raddr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_q
);

  localparam int BA_W = ADDR_W + 2;

  state_e state_reg, state_next;

  logic [2:0]      f3_a    [2];
  logic [BA_W-1:0] addr_a  [2];
  logic [31:0]     wdata_a [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign f3_a[gi]    = bus.req_funct3[gi*3 +: 3];
      assign addr_a[gi]  = bus.req_addr[gi*BA_W +: BA_W];
      assign wdata_a[gi] = bus.req_wdata[gi*32 +: 32];
    end
  endgenerate

  logic              last_reg;
  logic              gnt_reg;
  logic [ADDR_W-1:0] word_addr_reg;
  logic [3:0]        be_reg;
  logic [31:0]       wdata_reg;
  logic [2:0]        f3_reg;
  logic [1:0]        lo_reg;
  logic              err_reg;
  logic [31:0]       rdata_reg;

  logic              win;
  logic              accept;
  logic [2:0]        sel_f3;
  logic [BA_W-1:0]   sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_we;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic              lane_err;
  logic [31:0]       lane_rdata;

  // On contention the requester not granted last time wins.
  assign win       = bus.req_valid[1] & (~bus.req_valid[0] | ~last_reg);
  assign sel_f3    = f3_a[win];
  assign sel_addr  = addr_a[win];
  assign sel_wdata = wdata_a[win];
  assign sel_we    = bus.req_we[win];

  ram_lane_align u_lane (
    .funct3     (sel_f3),
    .we         (sel_we),
    .addr_lo    (sel_addr[1:0]),
    .wdata      (sel_wdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .err        (lane_err),
    .ld_funct3  (f3_reg),
    .ld_addr_lo (lo_reg),
    .q          (ram_q),
    .rdata      (lane_rdata)
  );

  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    bus.req_ready = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          accept             = 1'b1;
          bus.req_ready[win] = 1'b1;
          if (lane_err) begin
            state_next = ST_RESP;
          end else if (sel_we) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_READ;
          end
        end
      end
      ST_WRITE:   state_next = ST_RESP;
      ST_READ:    state_next = ST_RD_WAIT;
      ST_RD_WAIT: state_next = ST_RESP;
      ST_RESP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      last_reg      <= 1'b1;
      gnt_reg       <= 1'b0;
      word_addr_reg <= '0;
      be_reg        <= BE_NONE;
      wdata_reg     <= '0;
      f3_reg        <= '0;
      lo_reg        <= '0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_reg      <= win;
        gnt_reg       <= win;
        word_addr_reg <= sel_addr[BA_W-1:2];
        be_reg        <= lane_be;
        wdata_reg     <= lane_wdata;
        f3_reg        <= sel_f3;
        lo_reg        <= sel_addr[1:0];
        err_reg       <= lane_err;
        rdata_reg     <= '0;
      end else if (state_reg == ST_RD_WAIT) begin
        rdata_reg <= lane_rdata;
      end
    end
  end

  assign ram_we    = (state_reg == ST_WRITE);
  assign ram_be    = ram_we ? be_reg : BE_NONE;
  assign ram_wdata = ram_we ? wdata_reg : '0;
  assign ram_waddr = word_addr_reg;
  assign ram_raddr = word_addr_reg;

  assign bus.rsp_valid = (state_reg == ST_RESP) ? (gnt_reg ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata = (state_reg == ST_RESP) ? rdata_reg : '0;
  assign bus.rsp_err   = (state_reg == ST_RESP) & err_reg;

endmodule
